// File: rtl/spislave_io.sv
// spislave_io: cpu11-bus SPI mode-0 slave (MSB first, 8-bit frames), pins oversampled in clk.
// Optional macro SPISLV_RXFIFO_EN replaces the RX holding register with a FIFO_DEPTH-entry FIFO.
module spislave_io #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] AD,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs,
  output logic       irq,
  input  logic       ssck,
  input  logic       smosi,
  output logic       smiso,
  output logic       smiso_oe,
  input  logic       sss
);
  logic [SYNC_STAGES-1:0] ssck_sync_q, ssck_sync_d, mosi_sync_q, mosi_sync_d, sss_sync_q, sss_sync_d;
  logic       ssck_prev_q, ssck_prev_d, sss_prev_q, sss_prev_d;
  logic [3:0] ctrl_q, ctrl_d;
  logic [7:0] fill_q, fill_d, tx_hold_q, tx_hold_d, tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
  logic       txe_q, txe_d, ovr_q, ovr_d, udr_q, udr_d, ssf_q, ssf_d;
  logic       reload_q, reload_d, active_q, active_d;
  logic [2:0] cnt_q, cnt_d;

  logic       ssck_s, mosi_s, sss_s, en, wr, rd;
  logic       sss_fall, sss_rise, start, stop, run, sck_rise, sck_fall;
  logic       rx_pop, rx_push, rx_ovf, rxf, rx_full;
  logic [7:0] rx_byte, rx_head, tx_next;

  assign ssck_s   = ssck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sss_s    = sss_sync_q[SYNC_STAGES-1];
  assign en       = ctrl_q[0];
  assign wr       = cs & ~rw;
  assign rd       = cs & rw;
  assign sss_fall = sss_prev_q & ~sss_s;
  assign sss_rise = ~sss_prev_q & sss_s;
  // Clearing EN while selected ends the frame exactly like a deselect.
  assign start    = ~active_q & en & sss_fall;
  assign stop     = active_q & (sss_rise | ~en);
  assign run      = active_q & ~stop;
  assign sck_rise = run & ~ssck_prev_q & ssck_s;
  assign sck_fall = run & ssck_prev_q & ~ssck_s;
  assign rx_pop   = rd && (AD == 3'd0);
  assign rx_byte  = {rx_shift_q[6:0], mosi_s};
  assign rx_push  = sck_rise && (cnt_q == 3'd7);
  assign tx_next  = txe_q ? fill_q : tx_hold_q;

  always_comb begin
    ssck_sync_d = {ssck_sync_q[SYNC_STAGES-2:0], ssck};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], smosi};
    sss_sync_d  = {sss_sync_q[SYNC_STAGES-2:0], sss};
    ssck_prev_d = ssck_s;
    sss_prev_d  = sss_s;
    ctrl_d      = ctrl_q;
    fill_d      = fill_q;
    tx_hold_d   = tx_hold_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    txe_d       = txe_q;
    ovr_d       = ovr_q;
    udr_d       = udr_q;
    ssf_d       = ssf_q;
    reload_d    = reload_q;
    active_d    = active_q;
    cnt_d       = cnt_q;

    // Clears first so that any set event later in this block wins.
    if (wr && AD == 3'd1) begin
      ovr_d = ovr_q & ~DI[2];
      udr_d = udr_q & ~DI[3];
      ssf_d = ssf_q & ~DI[5];
    end
    if (wr && AD == 3'd2) ctrl_d = DI[3:0];
    if (wr && AD == 3'd3) fill_d = DI;

    if (start || (sck_fall && reload_q)) begin
      tx_shift_d = tx_next;
      if (txe_q) udr_d = 1'b1;
      else       txe_d = 1'b1;
    end else if (sck_fall) begin
      tx_shift_d = {tx_shift_q[6:0], 1'b0};
    end
    if (sck_fall) reload_d = 1'b0;

    if (sck_rise) begin
      rx_shift_d = rx_byte;
      cnt_d      = cnt_q + 3'd1;
      if (cnt_q == 3'd7) reload_d = 1'b1;
    end
    if (rx_ovf) ovr_d = 1'b1;

    if (start) begin
      active_d = 1'b1;
      cnt_d    = 3'd0;
      reload_d = 1'b0;
    end
    if (stop) begin
      active_d = 1'b0;
      cnt_d    = 3'd0;
      reload_d = 1'b0;
      if (en && sss_rise) ssf_d = 1'b1;
    end

    // A TX load in this cycle already sampled the old holding state.
    if (wr && AD == 3'd0) begin
      tx_hold_d = DI;
      txe_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ssck_sync_q <= '0;
      mosi_sync_q <= '0;
      sss_sync_q  <= '1;
      ssck_prev_q <= 1'b0;
      sss_prev_q  <= 1'b1;
      ctrl_q      <= '0;
      fill_q      <= 8'hFF;
      tx_hold_q   <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      txe_q       <= 1'b1;
      ovr_q       <= 1'b0;
      udr_q       <= 1'b0;
      ssf_q       <= 1'b0;
      reload_q    <= 1'b0;
      active_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      ssck_sync_q <= ssck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sss_sync_q  <= sss_sync_d;
      ssck_prev_q <= ssck_prev_d;
      sss_prev_q  <= sss_prev_d;
      ctrl_q      <= ctrl_d;
      fill_q      <= fill_d;
      tx_hold_q   <= tx_hold_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      txe_q       <= txe_d;
      ovr_q       <= ovr_d;
      udr_q       <= udr_d;
      ssf_q       <= ssf_d;
      reload_q    <= reload_d;
      active_q    <= active_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef SPISLV_RXFIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [7:0]  fifo_q [FIFO_DEPTH];
  logic [7:0]  fifo_d [FIFO_DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic [7:0]  last_q, last_d;
  logic        do_pop, do_push;

  assign rxf     = (wp_q != rp_q);
  assign rx_full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign do_pop  = rx_pop & rxf;
  assign do_push = rx_push & (~rx_full | do_pop);
  assign rx_ovf  = rx_push & ~do_push;
  assign rx_head = rxf ? fifo_q[rp_q[AW-1:0]] : last_q;

  always_comb begin
    fifo_d = fifo_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    last_d = last_q;
    if (do_pop) begin
      rp_d   = rp_q + 1'b1;
      last_d = fifo_q[rp_q[AW-1:0]];
    end
    if (do_push) begin
      fifo_d[wp_q[AW-1:0]] = rx_byte;
      wp_d = wp_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      last_q <= '0;
    end else begin
      fifo_q <= fifo_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      last_q <= last_d;
    end
  end
`else
  logic [7:0] rx_hold_q, rx_hold_d;
  logic       rxf_q, rxf_d;

  assign rxf     = rxf_q;
  assign rx_head = rx_hold_q;
  assign rx_full = 1'b0;
  assign rx_ovf  = rx_push & rxf_q & ~rx_pop;

  always_comb begin
    rx_hold_d = rx_hold_q;
    rxf_d     = rxf_q;
    if (rx_pop) rxf_d = 1'b0;
    if (rx_push) begin
      rx_hold_d = rx_byte;
      rxf_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_hold_q <= '0;
      rxf_q     <= 1'b0;
    end else begin
      rx_hold_q <= rx_hold_d;
      rxf_q     <= rxf_d;
    end
  end
`endif

  always_comb begin
    DO = 8'hFF;
    case (AD)
      3'd0:    DO = rx_head;
      3'd1:    DO = {(cnt_q != 3'd0), rx_full, ssf_q, ~sss_s, udr_q, ovr_q, txe_q, rxf};
      3'd2:    DO = {4'b0000, ctrl_q};
      3'd3:    DO = fill_q;
      default: DO = 8'hFF;
    endcase
  end

  assign irq      = (ctrl_q[1] & rxf) | (ctrl_q[2] & txe_q) | (ctrl_q[3] & ssf_q);
  assign smiso_oe = active_q;
  assign smiso    = active_q ? tx_shift_q[7] : 1'b1;
endmodule

// File: doc/spislave_io.md
Name: spislave_io

Overview:
- Memory-mapped SPI slave (target) peripheral on the cpu11 bus; the other end of the SPI master peripheral, so the board can be clocked by an external SPI master.
- Sits in the $E6C0–$E6DF I/O window beside the existing SPI master; decoded by the mainboard like the other peripherals.
- Supports SPI mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames.
- All SPI inputs are oversampled in the system clock domain.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for ssck/smosi/sss (minimum 2).
- FIFO_DEPTH, 4, RX FIFO entries; used only with SPISLV_RXFIFO_EN; power of 2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous active-low reset.
- AD  input  3  register select.
- DI  input  8  write data from CPU.
- DO  output  8  read data to CPU; combinational from AD.
- rw  input  1  1=read, 0=write.
- cs  input  1  chip select; high for exactly one clk per access.
- irq  output  1  level interrupt.
- ssck  input  1  SPI clock from external master.
- smosi  input  1  master-out data.
- smiso  output  1  slave-out data.
- smiso_oe  output  1  smiso drive enable.
- sss  input  1  slave select, active low.

Behaviour:
- Reset (rst=0, async): CTRL=0, FILL=$FF, RXF=0, TXE=1, OVR/UDR/SSF=0, shifters=0, bit count=0, irq=0, smiso=1, smiso_oe=0.
- Register map (write takes effect on posedge clk when cs&!rw):
  - 0 DATA: read returns RX holding register; the read pops it (RXF<=0) at posedge when cs&rw. Write loads TX holding (TXE<=0).
  - 1 STATUS (read-only except W1C): b0 RXF, b1 TXE, b2 OVR, b3 UDR, b4 SEL (synced !sss), b5 SSF, b7 BUSY (bit count≠0). Writing 1 to b2/b3/b5 clears that bit.
  - 2 CTRL (R/W): b0 EN, b1 RXIE, b2 TXIE, b3 SSIE.
  - 3 FILL (R/W): byte transmitted when TX holding is empty.
  - 4–7: read $FF; writes ignored.
- irq = (RXIE&RXF) | (TXIE&TXE) | (SSIE&SSF).
- SPI inputs pass through SYNC_STAGES flops. Edges are detected on synced ssck. ssck frequency must be ≤ clk/8; no behaviour is guaranteed above that.
- EN=0: SPI pins ignored, smiso_oe=0, bit count held at 0. Registers remain accessible.
- sss assert (synced falling edge, EN=1):
  - tx_shift loads the TX holding register (TXE<=1), or FILL with UDR<=1 if TXE was already 1.
  - Bit count<=0; smiso_oe<=1; smiso=tx_shift[7].
- ssck rising edge while selected: rx_shift <= {rx_shift[6:0], smosi}; count+1.
- On the 8th rising edge (byte complete):
  - RX holding <= byte; RXF<=1. If RXF was already 1 and not popped that cycle, OVR<=1 and the new byte overwrites.
  - Count<=0; reload pending set.
- ssck falling edge while selected:
  - If reload pending: tx_shift loads next TX byte or FILL, using the same TXE/UDR rules as sss assert.
  - Otherwise tx_shift shifts left.
  - smiso always = tx_shift[7].
- sss deassert (synced rising edge): smiso_oe<=0, smiso<=1, SSF<=1. A partial byte is discarded; RX is not updated and a consumed TX byte is lost. Count<=0.
- Simultaneous events:
  - CPU DATA read in the same cycle as byte complete: the new byte wins, RXF stays 1, no OVR.
  - CPU DATA write in the same cycle as a TX load: the load samples pre-write state (may use FILL, UDR set); the write then sets TXE<=0.
  - W1C in the same cycle as a set event: set wins.
- EN cleared mid-byte: treated as sss deassert, except SSF is not set.

Optional Feature:
- Macro SPISLV_RXFIFO_EN.
- Defined: RX holding is a FIFO_DEPTH-entry FIFO.
  - RXF = not empty; DATA read pops the head; a read of an empty FIFO returns the last head value.
  - Byte complete when full: the byte is dropped, OVR<=1.
  - STATUS b6 = FIFO full.
- Undefined: single holding register as above; STATUS b6 reads 0.

Test Plan:
- Reset, then read regs 0–3 and 7 -> STATUS=$02, CTRL=$00, FILL=$FF, reg 7=$FF, irq=0, smiso_oe=0.
- CTRL=$01, DATA=$A5. Master (clk/16) sends $3C -> master receives $A5; STATUS RXF=1, TXE=1; DATA read=$3C; then RXF=0.
- TX empty, FILL=$5A, master sends 2 bytes $11,$22 -> master receives $5A,$5A; UDR=1; write $08 to STATUS clears UDR.
- Two bytes with no CPU read -> OVR=1, DATA=second byte. With SPISLV_RXFIFO_EN: both $11,$22 read back in order, OVR=0.
- sss deasserted after 4 bits of $F0 -> RXF unchanged, SSF=1, BUSY=0. With SSIE=1, irq=1 until SSF is cleared.
- CTRL=$03, byte completes in the same clk as a DATA read -> RXF stays 1, OVR=0, irq stays 1.
